pipeline_frontend_ctrl: RTL and testbench

//  Consumer side of the load-use hazard interface. Owns the PC register, the IF/ID pipeline

---
 rtl/pipeline_frontend_ctrl.sv | 116 +++++++++++
 tb/tb_pipeline_frontend_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_frontend_ctrl.sv
// pipeline_frontend_ctrl
// Front end of the pipeline, on the consumer side of the load-use hazard unit.
// Owns the PC register, the IF/ID pipeline register and the ID/EX control register.
// It holds PC and IF/ID, injects bubbles into ID/EX, and redirects and flushes on a
// taken branch. It also keeps stall/flush statistics and a consecutive-stall watchdog.
// All outputs are registered. There is no handshake: the hazard unit's controls are
// sampled on every rising edge.
module pipeline_frontend_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          CTRL_W    = 10,
  parameter int          CNT_W     = 16,
  parameter int          MAX_STALL = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              PCWrite,
  input  logic              IF_ID_Write,
  input  logic              Control_Unit_Sel,
  input  logic              branch_taken,
  input  logic [31:0]       branch_target,
  input  logic [31:0]       instr_in,
  input  logic [CTRL_W-1:0] id_ctrl_in,
  output logic [31:0]       pc_out,
  output logic [31:0]       if_id_instr,
  output logic [31:0]       if_id_pc4,
  output logic              if_id_valid,
  output logic [CTRL_W-1:0] id_ex_ctrl,
  output logic [1:0]        fe_state,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count,
  output logic              stall_timeout
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } fe_state_t;

  localparam logic [7:0] MAX_STALL_W = 8'(MAX_STALL);

  fe_state_t  state, state_next;
  logic [7:0] consec_stall;
  logic       stall_edge;

  // A stall edge is one where the PC is frozen and no branch overrides it.
  assign stall_edge = !PCWrite && !branch_taken;
  assign fe_state   = state;

  // Front-end state register.
  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_next;
  end

  // Next state: a branch always flushes; otherwise PCWrite selects RUN or STALL.
  always_comb begin
    state_next = state;
    if (branch_taken)  state_next = FLUSH;
    else if (PCWrite)  state_next = RUN;
    else               state_next = STALL;
  end

  // PC register: redirect on branch (word aligned), advance or hold otherwise.
  always_ff @(posedge clk) begin
    if (rst)               pc_out <= RESET_PC;
    else if (branch_taken) pc_out <= branch_target & 32'hFFFF_FFFC;
    else if (PCWrite)      pc_out <= pc_out + 32'd4;
  end

  // IF/ID register: flushed to a NOP on branch, loaded or held per IF_ID_Write.
  always_ff @(posedge clk) begin
    if (rst || branch_taken) begin
      if_id_instr <= 32'h0;
      if_id_pc4   <= 32'h0;
      if_id_valid <= 1'b0;
    end else if (IF_ID_Write) begin
      if_id_instr <= instr_in;
      if_id_pc4   <= pc_out + 32'd4;
      if_id_valid <= 1'b1;
    end
  end

  // ID/EX control: a bubble on flush, on hazard select or when ID holds no instruction.
  always_ff @(posedge clk) begin
    if (rst || branch_taken || !Control_Unit_Sel || !if_id_valid)
      id_ex_ctrl <= '0;
    else
      id_ex_ctrl <= id_ctrl_in;
  end

  // Saturating statistics counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall_edge && (stall_count != '1))   stall_count <= stall_count + CNT_W'(1);
      if (branch_taken && (flush_count != '1)) flush_count <= flush_count + CNT_W'(1);
    end
  end

  // Watchdog: the run length stops at MAX_STALL, and any further stall edge trips the sticky flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      consec_stall  <= 8'd0;
      stall_timeout <= 1'b0;
    end else if (stall_edge) begin
      if (consec_stall >= MAX_STALL_W) stall_timeout <= 1'b1;
      else                             consec_stall  <= consec_stall + 8'd1;
    end else begin
      consec_stall <= 8'd0;
    end
  end

endmodule

// File: tb/tb_pipeline_frontend_ctrl.sv
// Bench for pipeline_frontend_ctrl.
// Two instances share one stimulus stream. Instance A uses the default parameters.
// Instance B uses a wrapping reset PC, 4-bit counters and a short watchdog. For every
// issued cycle the driver pushes the expected post-edge outputs of each instance, and
// a monitor pops and compares them one time unit after each rising edge.
module tb_pipeline_frontend_ctrl;

  localparam int W = 142;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, pcw, ifw, sel, br;
  logic [31:0] tgt, instr;
  logic [9:0]  ctrl_in;

  logic [31:0] a_pc, a_instr, a_pc4, b_pc, b_instr, b_pc4;
  logic        a_valid, a_to, b_valid, b_to;
  logic [9:0]  a_ctrl, b_ctrl;
  logic [1:0]  a_state, b_state;
  logic [15:0] a_sc, a_fc;
  logic [3:0]  b_sc, b_fc;

  pipeline_frontend_ctrl #(.RESET_PC(32'h0000_0000), .CTRL_W(10), .CNT_W(16), .MAX_STALL(8)) dut_a (
    .clk(clk), .rst(rst), .PCWrite(pcw), .IF_ID_Write(ifw), .Control_Unit_Sel(sel),
    .branch_taken(br), .branch_target(tgt), .instr_in(instr), .id_ctrl_in(ctrl_in),
    .pc_out(a_pc), .if_id_instr(a_instr), .if_id_pc4(a_pc4), .if_id_valid(a_valid),
    .id_ex_ctrl(a_ctrl), .fe_state(a_state), .stall_count(a_sc), .flush_count(a_fc),
    .stall_timeout(a_to));

  pipeline_frontend_ctrl #(.RESET_PC(32'hFFFF_FFF8), .CTRL_W(10), .CNT_W(4), .MAX_STALL(3)) dut_b (
    .clk(clk), .rst(rst), .PCWrite(pcw), .IF_ID_Write(ifw), .Control_Unit_Sel(sel),
    .branch_taken(br), .branch_target(tgt), .instr_in(instr), .id_ctrl_in(ctrl_in),
    .pc_out(b_pc), .if_id_instr(b_instr), .if_id_pc4(b_pc4), .if_id_valid(b_valid),
    .id_ex_ctrl(b_ctrl), .fe_state(b_state), .stall_count(b_sc), .flush_count(b_fc),
    .stall_timeout(b_to));

  // Scoreboard
  logic [W-1:0] exp_a[$];
  logic [W-1:0] exp_b[$];
  int checks = 0;
  int errors = 0;

  // Reference model: architectural state per instance, with counters as plain integers
  logic [31:0] m_pc[2], m_instr[2], m_pc4[2];
  logic        m_valid[2], m_to[2];
  logic [9:0]  m_ctrl[2];
  int          m_state[2], m_sc[2], m_fc[2], m_run[2];
  logic [31:0] p_rpc[2];
  int          p_cmax[2], p_mst[2];

  function automatic logic [W-1:0] pack(logic [31:0] pc, logic [31:0] ins, logic [31:0] pc4,
                                        logic v, logic [9:0] c, logic [1:0] st,
                                        logic [15:0] sc, logic [15:0] fc, logic to);
    return {pc, ins, pc4, v, c, st, sc, fc, to};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_vec(input string tag, input logic [W-1:0] e, input logic [W-1:0] a);
    check({tag, ".pc_out"},        a[141:110],         e[141:110]);
    check({tag, ".if_id_instr"},   a[109:78],          e[109:78]);
    check({tag, ".if_id_pc4"},     a[77:46],           e[77:46]);
    check({tag, ".if_id_valid"},   {31'b0, a[45]},     {31'b0, e[45]});
    check({tag, ".id_ex_ctrl"},    {22'b0, a[44:35]},  {22'b0, e[44:35]});
    check({tag, ".fe_state"},      {30'b0, a[34:33]},  {30'b0, e[34:33]});
    check({tag, ".stall_count"},   {16'b0, a[32:17]},  {16'b0, e[32:17]});
    check({tag, ".flush_count"},   {16'b0, a[16:1]},   {16'b0, e[16:1]});
    check({tag, ".stall_timeout"}, {31'b0, a[0]},      {31'b0, e[0]});
  endtask

  // Driver: apply one cycle of inputs, advance the model, push expectations, wait a cycle
  task automatic step(input logic r, input logic p, input logic f, input logic s, input logic b,
                      input logic [31:0] t, input logic [31:0] ins, input logic [9:0] c);
    rst = r; pcw = p; ifw = f; sel = s; br = b; tgt = t; instr = ins; ctrl_in = c;
    for (int i = 0; i < 2; i++) begin
      if (r) begin
        m_pc[i] = p_rpc[i]; m_instr[i] = 0; m_pc4[i] = 0; m_valid[i] = 0; m_ctrl[i] = 0;
        m_state[i] = 0; m_sc[i] = 0; m_fc[i] = 0; m_run[i] = 0; m_to[i] = 0;
      end else if (b) begin
        m_pc[i] = {t[31:2], 2'b00};
        m_instr[i] = 0; m_pc4[i] = 0; m_valid[i] = 0; m_ctrl[i] = 0;
        m_fc[i] = (m_fc[i] < p_cmax[i]) ? m_fc[i] + 1 : p_cmax[i];
        m_state[i] = 2; m_run[i] = 0;
      end else begin
        m_ctrl[i] = (s && m_valid[i]) ? c : 10'd0;
        if (f) begin
          m_instr[i] = ins; m_pc4[i] = m_pc[i] + 32'd4; m_valid[i] = 1;
        end
        if (p) begin
          m_pc[i] = m_pc[i] + 32'd4; m_state[i] = 0; m_run[i] = 0;
        end else begin
          m_state[i] = 1;
          m_sc[i] = (m_sc[i] < p_cmax[i]) ? m_sc[i] + 1 : p_cmax[i];
          m_run[i]++;
          if (m_run[i] > p_mst[i]) m_to[i] = 1;
        end
      end
    end
    exp_a.push_back(pack(m_pc[0], m_instr[0], m_pc4[0], m_valid[0], m_ctrl[0], 2'(m_state[0]),
                         16'(m_sc[0]), 16'(m_fc[0]), m_to[0]));
    exp_b.push_back(pack(m_pc[1], m_instr[1], m_pc4[1], m_valid[1], m_ctrl[1], 2'(m_state[1]),
                         16'(m_sc[1]), 16'(m_fc[1]), m_to[1]));
    @(negedge clk);
  endtask

  task automatic run_cycle();
    step(0, 1, 1, 1, 0, 32'h0, $urandom, 10'($urandom));
  endtask

  task automatic stall_cycles(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 32'h0, $urandom, 10'($urandom));
  endtask

  // Monitor: every cycle each DUT presents a full output set to compare
  initial begin
    logic [W-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_a.size() > 0) begin
        e = exp_a.pop_front();
        compare_vec("A", e, pack(a_pc, a_instr, a_pc4, a_valid, a_ctrl, a_state, a_sc, a_fc, a_to));
      end
      if (exp_b.size() > 0) begin
        e = exp_b.pop_front();
        compare_vec("B", e, pack(b_pc, b_instr, b_pc4, b_valid, b_ctrl, b_state,
                                 {12'b0, b_sc}, {12'b0, b_fc}, b_to));
      end
    end
  end

  // Stimulus
  initial begin
    logic p, f, s, r, b;
    p_rpc[0] = 32'h0000_0000; p_cmax[0] = 65535; p_mst[0] = 8;
    p_rpc[1] = 32'hFFFF_FFF8; p_cmax[1] = 15;    p_mst[1] = 3;

    // Reset for two cycles, then straight-line fetch (B also shows the PC wrapping)
    step(1, 0, 0, 0, 0, 32'h0, 32'h0, 10'h0);
    step(1, 0, 0, 0, 0, 32'h0, 32'h0, 10'h0);
    for (int k = 0; k < 3; k++) step(0, 1, 1, 1, 0, 32'h0, 32'h8C01_0004, 10'h155);

    // Single-cycle load-use stall, then resume
    stall_cycles(1);
    run_cycle();
    run_cycle();

    // Taken branch during a stall request, then recovery
    step(0, 0, 0, 0, 1, 32'h0000_0043, $urandom, 10'h3FF);
    run_cycle();
    // Back-to-back branches, and a branch straight out of a stall
    step(0, 1, 1, 1, 1, 32'h0000_1001, $urandom, 10'h2AA);
    step(0, 1, 1, 1, 1, 32'h0000_2002, $urandom, 10'h2AA);
    stall_cycles(2);
    step(0, 0, 1, 1, 1, 32'h0000_3007, $urandom, 10'h1);
    run_cycle();

    // Watchdog: exactly eight stall cycles must not trip A; nine must, and it must stick
    stall_cycles(8);
    run_cycle();
    stall_cycles(9);
    run_cycle();
    run_cycle();

    // PCWrite without IF_ID_Write, and the reverse
    step(0, 1, 0, 1, 0, 32'h0, $urandom, 10'h0F0);
    step(0, 0, 1, 1, 0, 32'h0, $urandom, 10'h00F);

    // Long stall saturates B's counter, then reset arrives mid-stall
    stall_cycles(20);
    step(1, 0, 0, 0, 0, 32'h0, $urandom, 10'h3FF);
    stall_cycles(2);
    step(0, 0, 0, 0, 1, 32'h0000_0100, $urandom, 10'h3FF);
    step(1, 1, 1, 1, 0, 32'h0, $urandom, 10'h3FF);
    run_cycle();

    // Randomised traffic with occasional long stall bursts
    for (int k = 0; k < 400; k++) begin
      if (k % 97 == 50) stall_cycles($urandom_range(5, 12));
      r = ($urandom_range(0, 99) < 2);
      b = ($urandom_range(0, 99) < 8);
      p = ($urandom_range(0, 99) < 70);
      f = p ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 9) == 0);
      s = p ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 9) == 0);
      step(r, p, f, s, b, $urandom, $urandom, 10'($urandom));
    end

    repeat (2) @(negedge clk);
    checks++;
    if (exp_a.size() != 0 || exp_b.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d pending expectations, expected 0/0", exp_a.size(), exp_b.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
